// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the flagged adder, the result stage and its consumer.
// Upstream/downstream (master) drive the in_* data, out_ready and clr_sticky; the stage (slave) drives the rest.
interface alu_result_stage_if #(
    parameter int l     = 16,
    parameter int CNT_W = 8
);
    logic [l-1:0]     in_sum;
    logic             in_overflow;
    logic             in_carry;
    logic             in_valid;
    logic             in_ready;
    logic [l-1:0]     out_result;
    logic [3:0]       out_flags;
    logic             out_valid;
    logic             out_ready;
    logic             clr_sticky;
    logic             sticky_v;
    logic [CNT_W-1:0] v_count;

    modport master (
        output in_sum, in_overflow, in_carry, in_valid, out_ready, clr_sticky,
        input  in_ready, out_result, out_flags, out_valid, sticky_v, v_count
    );

    modport slave (
        input  in_sum, in_overflow, in_carry, in_valid, out_ready, clr_sticky,
        output in_ready, out_result, out_flags, out_valid, sticky_v, v_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// Result stage behind the 16-bit flagged adder: 2-entry skid buffer storing {sum, N,Z,C,V},
// plus a sticky overflow bit and a saturating overflow-event counter.
module alu_result_stage #(
    parameter int l     = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_stage_if.slave    bus,
    output logic [1:0]           o_dbg_state
);
    // Handshake: a transfer happens on a rising clk where valid && ready on that side.
    // in_ready depends on the state register only, never on out_ready or in_valid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [l-1:0]     r_head_res;
    logic [3:0]       r_head_flg;
    logic [l-1:0]     r_skid_res;
    logic [3:0]       r_skid_flg;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic             w_acc;
    logic             w_del;
    logic [3:0]       w_in_flags;
    logic             w_load_head;
    logic             w_load_skid;
    logic             w_skid_to_head;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sticky_next;

    assign bus.in_ready   = (r_state != S_TWO);
    assign bus.out_valid  = (r_state != S_EMPTY);
    assign bus.out_result = r_head_res;
    assign bus.out_flags  = r_head_flg;
    assign bus.sticky_v   = r_sticky;
    assign bus.v_count    = r_cnt;
    assign o_dbg_state    = r_state;

    assign w_acc      = bus.in_valid && bus.in_ready;
    assign w_del      = bus.out_valid && bus.out_ready;
    assign w_in_flags = {bus.in_sum[l-1], (bus.in_sum == '0), bus.in_carry, bus.in_overflow};

    always_comb begin
        w_next_state   = r_state;
        w_load_head    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_head = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_next_state = S_ONE;
                    w_load_head  = 1'b1;
                end
            end
            S_ONE: begin
                if (w_acc && !w_del) begin
                    w_next_state = S_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_acc && w_del) begin
                    w_load_head  = 1'b1;
                end else if (w_del) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_del) begin
                    w_next_state   = S_ONE;
                    w_skid_to_head = 1'b1;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    // Clear takes effect first, so a same-cycle V=1 accept still counts once.
    always_comb begin
        w_cnt_base    = bus.clr_sticky ? '0 : r_cnt;
        w_cnt_next    = w_cnt_base;
        if (w_acc && bus.in_overflow && (w_cnt_base != CNT_MAX)) begin
            w_cnt_next = w_cnt_base + 1'b1;
        end
        w_sticky_next = (bus.clr_sticky ? 1'b0 : r_sticky) | (w_acc & bus.in_overflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_res <= '0;
            r_head_flg <= '0;
            r_skid_res <= '0;
            r_skid_flg <= '0;
        end else begin
            if (w_load_head) begin
                r_head_res <= bus.in_sum;
                r_head_flg <= w_in_flags;
            end else if (w_skid_to_head) begin
                r_head_res <= r_skid_res;
                r_head_flg <= r_skid_flg;
            end
            if (w_load_skid) begin
                r_skid_res <= bus.in_sum;
                r_skid_flg <= w_in_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sticky <= w_sticky_next;
            r_cnt    <= w_cnt_next;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random valid/ready traffic checked
// against a queue-based FIFO model and a behavioural sticky/counter model.
module tb_alu_result_stage;
    localparam int L  = 16;
    localparam int CW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    alu_result_stage_if #(.l(L), .CNT_W(CW)) bus();

    alu_result_stage #(.l(L), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [L+3:0]  exp_q[$];
    logic          m_sticky = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic          prev_stall = 1'b0;
    logic [L+3:0]  prev_out = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_flags(input logic [L-1:0] s, input logic c, input logic v);
        return {s[L-1], (s == 0), c, v};
    endfunction

    // Expected entries are recorded when the upstream offer is accepted.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready)
            exp_q.push_back({bus.in_sum, ref_flags(bus.in_sum, bus.in_carry, bus.in_overflow)});
    end

    always @(negedge clk) begin
        logic [L+3:0] e;
        if (rst_n) begin
            if (prev_stall && bus.out_valid)
                check("stall_stable", {bus.out_result, bus.out_flags}, prev_out);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h with empty expected queue", bus.out_result);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard", {bus.out_result, bus.out_flags}, e);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_result, bus.out_flags};
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("sticky_v", bus.sticky_v, m_sticky);
            check("v_count", bus.v_count, m_cnt);
            if (bus.clr_sticky) begin
                m_sticky = 1'b0;
                m_cnt    = '0;
            end
            if (bus.in_valid && bus.in_ready && bus.in_overflow) begin
                m_sticky = 1'b1;
                if (m_cnt != (2**CW) - 1) m_cnt = m_cnt + 1'b1;
            end
        end else begin
            m_sticky = 1'b0;
            m_cnt    = '0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds the offer until the stage accepts it; returns 1 ns after the accepting edge.
    task automatic send(input logic [L-1:0] s, input logic v, input logic c);
        bus.in_sum      = s;
        bus.in_overflow = v;
        bus.in_carry    = c;
        bus.in_valid    = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                cycle();
                bus.in_valid = 1'b0;
                return;
            end
            cycle();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for sum 0x%0h", s);
        bus.in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_sticky   = 1'b0;
        m_cnt      = '0;
        prev_stall = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_v_count", bus.v_count, 0);
        check("rst_sticky_v", bus.sticky_v, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_flags", bus.out_flags, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [L-1:0] v;
        logic [1:0]   exp_cnt[5];
        logic         acc_seen;
        int           rdy_pct;

        bus.in_sum = '0;
        bus.in_overflow = 1'b0;
        bus.in_carry = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_sticky = 1'b0;
        cycle();
        apply_reset();

        // Known adder results: 0x7FFF+1 and 0xFFFF+1, accepted on the first edge after reset.
        bus.out_ready = 1'b1;
        send(16'h8000, 1'b1, 1'b0);
        check("t2_valid_a", bus.out_valid, 1);
        check("t2_flags_a", bus.out_flags, 4'b1001);
        send(16'h0000, 1'b0, 1'b1);
        check("t2_valid_b", bus.out_valid, 1);
        check("t2_flags_b", bus.out_flags, 4'b0110);
        check("t2_vcount", bus.v_count, 1);
        bus.out_ready = 1'b1;
        repeat (2) cycle();

        // Stalled consumer: two entries fill the buffer, the third waits upstream.
        bus.out_ready = 1'b0;
        send(16'h0011, 1'b0, 1'b0);
        send(16'h0022, 1'b0, 1'b0);
        check("t3_in_ready_full", bus.in_ready, 0);
        bus.in_sum = 16'h0033;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_hold_result", bus.out_result, 16'h0011);
            check("t3_hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("t3_drain_1", bus.out_result, 16'h0022);
        check("t3_drain_1v", bus.out_valid, 1);
        check("t3_ready_back", bus.in_ready, 1);
        cycle();
        bus.in_valid = 1'b0;
        check("t3_drain_2", bus.out_result, 16'h0033);
        check("t3_drain_2v", bus.out_valid, 1);
        cycle();
        check("t3_empty", bus.out_valid, 0);

        // Reset while both registers are full.
        bus.out_ready = 1'b0;
        send(16'h1234, 1'b1, 1'b0);
        send(16'h5678, 1'b0, 1'b1);
        check("t1_full", bus.in_ready, 0);
        apply_reset();

        // Simultaneous accept and deliver keep occupancy at one.
        send(16'h0100, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = L'($urandom);
            bus.in_sum = v;
            bus.in_overflow = 1'($urandom);
            bus.in_carry = 1'($urandom);
            bus.in_valid = 1'b1;
            cycle();
            check("t4_in_ready", bus.in_ready, 1);
            check("t4_head", bus.out_result, v);
        end
        bus.in_valid = 1'b0;
        repeat (2) cycle();

        // Saturating counter at CNT_W=2 and clear priority.
        bus.clr_sticky = 1'b1;
        cycle();
        bus.clr_sticky = 1'b0;
        check("t5_clr0", bus.v_count, 0);
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            send(L'($urandom), 1'b1, 1'b0);
            check("t5_sat", bus.v_count, exp_cnt[i]);
        end
        bus.clr_sticky = 1'b1;
        send(16'h4000, 1'b1, 1'b0);
        bus.clr_sticky = 1'b0;
        check("t5_clr_acc_sticky", bus.sticky_v, 1);
        check("t5_clr_acc_cnt", bus.v_count, 1);
        bus.clr_sticky = 1'b1;
        cycle();
        bus.clr_sticky = 1'b0;
        check("t5_clr_sticky", bus.sticky_v, 0);
        check("t5_clr_cnt", bus.v_count, 0);

        // Random traffic; the offer is held stable until accepted.
        acc_seen = 1'b0;
        rdy_pct = 50;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 1000 == 0) rdy_pct = $urandom_range(10, 100);
            if (!bus.in_valid || acc_seen) begin
                case ($urandom_range(0, 7))
                    0: v = 16'h0000;
                    1: v = 16'h8000;
                    2: v = 16'hFFFF;
                    default: v = L'($urandom);
                endcase
                bus.in_sum      = v;
                bus.in_overflow = 1'($urandom);
                bus.in_carry    = 1'($urandom);
                bus.in_valid    = ($urandom_range(0, 2) != 0);
            end
            bus.out_ready  = ($urandom_range(1, 100) <= rdy_pct);
            bus.clr_sticky = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            acc_seen = bus.in_valid && bus.in_ready;
            cycle();
        end

        bus.in_valid = 1'b0;
        bus.clr_sticky = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycle();
        cycle();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_out_valid", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 16-bit flagged adder.
- Captures the adder's sum, Overflow and Carry into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Derives the Zero and Negative flags at capture.
- Keeps a sticky overflow bit and a saturating overflow-event counter for the control/debug path.

Parameters:
l, 16, datapath width; must match the adder width.
CNT_W, 8, width of the overflow-event counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_sum  input  l  adder sum S.
in_overflow  input  1  adder Overflow.
in_carry  input  1  adder Carry.
in_valid  input  1  upstream offers a result this cycle.
in_ready  output  1  stage can accept a result this cycle.
out_result  output  l  head-entry result.
out_flags  output  4  head-entry flags {N,Z,C,V}; bit3=N, bit0=V.
out_valid  output  1  head entry present.
out_ready  input  1  downstream accepts the head entry this cycle.
clr_sticky  input  1  synchronous clear of the sticky bit and the counter.
sticky_v  output  1  set if any accepted entry had V=1 since the last clear or reset.
v_count  output  CNT_W  count of accepted entries with V=1, saturating.

Behaviour:
- Transfer rules:
  - Accept occurs when in_valid && in_ready at a rising clk.
  - Deliver occurs when out_valid && out_ready at a rising clk.
- Flags are computed from the input at accept and stored with the entry:
  - Z = (in_sum == 0).
  - N = in_sum[l-1].
  - C = in_carry.
  - V = in_overflow.
  - No further arithmetic is done; the entry is stored bit-exact.
- Storage: head register (drives out_*) plus skid register. State is EMPTY, ONE or TWO.
- Port derivation:
  - in_ready = (state != TWO), decoded from the state register only. There is no combinational path from out_ready or in_valid to in_ready.
  - out_valid = (state != EMPTY).
- Transitions (acc = accept, del = deliver):
  - EMPTY, acc → ONE. New entry goes to head.
  - ONE, acc and no del → TWO. New entry goes to skid.
  - ONE, del and no acc → EMPTY.
  - ONE, acc and del → ONE. New entry goes to head.
  - TWO, del → ONE. Skid moves to head. No accept is possible because in_ready=0.
  - In all other cases, state and data hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 entry per cycle when out_ready is held high.
- Order is strictly FIFO. No entry is dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, out_result and out_flags must not change.
- Sticky bit and counter, evaluated every clock:
  - clr_sticky is applied first, then the accept event.
  - Simultaneous clr_sticky and an accept with V=1 gives sticky_v=1 and v_count=1.
  - v_count saturates at 2^CNT_W-1 and never wraps.
  - Both count at accept time, not at deliver time.
- Reset (rst_n low, asynchronous, any cycle, including mid-transfer):
  - state=EMPTY, so in_ready=1 and out_valid=0.
  - out_result=0, out_flags=0, sticky_v=0, v_count=0. Skid contents are discarded.
  - The first accept is possible on the first rising clk with rst_n high.
- out_result and out_flags are don't-care to downstream while out_valid=0. They must still read 0 after reset until the first accept.

Test Plan:
1. Reset mid-stream with state=TWO → immediately out_valid=0, in_ready=1, v_count=0, sticky_v=0, out_result=0x0000.
2. out_ready=1; drive 0x7FFF+0x0001 (S=0x8000, V=1, C=0), then 0xFFFF+0x0001 (S=0x0000, V=0, C=1) → out_flags=1001 then 0110, each 1 cycle after accept; v_count=1.
3. out_ready=0; offer 3 back-to-back entries 0x0011, 0x0022, 0x0033 → first two accepted, in_ready=0 from the cycle after the 2nd accept, 0x0033 held upstream. Raise out_ready → delivered in order 0x0011, 0x0022, 0x0033 with no gap once draining, and out_result stable while stalled.
4. State ONE, simultaneous accept and deliver for 10 cycles with out_ready=1 → state stays ONE, in_ready stays 1, all 10 values delivered in order.
5. CNT_W=2; accept 5 entries with V=1 → v_count goes 1,2,3,3,3; then clr_sticky together with a V=1 accept → sticky_v=1, v_count=1; clr_sticky alone → both 0.
6. Random valid/ready toggling for 10k cycles against a reference FIFO model → no loss, duplication or reordering; flags match {S[15], S==0, C, V}.
